// File: rtl/rename_map_pkg.sv
// Shared rename-stage types: sizing constants, rename FSM states and the renamed-uop record.
package rename_map_pkg;

  localparam int ARCH = 32;
  localparam int PHYS = 64;
  localparam int AW   = $clog2(ARCH);
  localparam int PW   = $clog2(PHYS);

  typedef enum logic {
    IDLE,
    RECLAIM
  } state_e;

  typedef struct packed {
    logic [PW-1:0] prs1;
    logic [PW-1:0] prs2;
    logic [PW-1:0] prd;
    logic [PW-1:0] old_prd;
    logic          rd_we;
  } ren_uop_t;

endpackage

// File: rtl/rename_map_lsb_find.sv
// Lowest-set-bit finder: index of the least significant 1 in vec, plus an any-bit-set flag.
module lsb_find #(
  parameter  int W  = 64,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register-rename stage: speculative/retirement RATs, free-list handshake and
// post-flush reclamation of squashed physical registers, one per cycle.
module rename_map
  import rename_map_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ren_valid,
  output logic          ren_ready,
  input  logic [AW-1:0] ren_rs1,
  input  logic [AW-1:0] ren_rs2,
  input  logic [AW-1:0] ren_rd,
  input  logic          ren_rd_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_prs1,
  output logic [PW-1:0] out_prs2,
  output logic [PW-1:0] out_prd,
  output logic [PW-1:0] out_old_prd,
  output logic          out_rd_we,
  output logic          fl_alloc,
  input  logic          fl_alloc_ok,
  input  logic [PW-1:0] fl_prd,
  output logic          fl_free_en,
  output logic [PW-1:0] fl_prd_free,
  input  logic          cmt_valid,
  input  logic          cmt_rd_we,
  input  logic [AW-1:0] cmt_rd,
  input  logic [PW-1:0] cmt_prd,
  input  logic [PW-1:0] cmt_old_prd,
  input  logic          flush,
  output logic          busy
);

  state_e          state, state_nx;
  logic [PW-1:0]   spec_rat [ARCH];
  logic [PW-1:0]   arch_rat [ARCH];
  logic [PHYS-1:0] inflight;

  ren_uop_t        uop_p0, uop_p1;
  logic            vld_p1;

  logic            idle, need, fire, cmt_we, do_flush, reclaim;
  logic [PW-1:0]   rcl_idx;
  logic            rcl_any;

  lsb_find #(.W(PHYS)) u_lsb (
    .vec (inflight),
    .idx (rcl_idx),
    .any (rcl_any)
  );

  always_comb begin
    idle      = (state == IDLE);
    need      = ren_rd_we && (ren_rd != '0);
    ren_ready = idle && !flush && (!vld_p1 || out_ready) && (!need || fl_alloc_ok);
    fire      = ren_valid && ren_ready;
    fl_alloc  = fire && need;
    // Commits are only legal in IDLE, which keeps the free-list push port single-sourced.
    cmt_we    = idle && cmt_valid && cmt_rd_we;
    do_flush  = idle && flush;
    reclaim   = (state == RECLAIM) && rcl_any;
    busy      = (state == RECLAIM);

    fl_free_en  = cmt_we || reclaim;
    fl_prd_free = '0;
    if (cmt_we)       fl_prd_free = cmt_old_prd;
    else if (reclaim) fl_prd_free = rcl_idx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (flush) state_nx = RECLAIM;
      RECLAIM: if (!rcl_any) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: source lookups read the RAT before this cycle's dest update.
  always_comb begin
    uop_p0.prs1    = spec_rat[ren_rs1];
    uop_p0.prs2    = spec_rat[ren_rs2];
    uop_p0.old_prd = spec_rat[ren_rd];
    uop_p0.prd     = need ? fl_prd : '0;
    uop_p0.rd_we   = need;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      inflight <= '0;
    end else begin
      state <= state_nx;
      if (cmt_we)   inflight[cmt_prd] <= 1'b0;
      if (fl_alloc) inflight[fl_prd]  <= 1'b1;
      if (reclaim)  inflight[rcl_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH; i++) begin
        spec_rat[i] <= PW'(i);
        arch_rat[i] <= PW'(i);
      end
    end else begin
      if (cmt_we && (cmt_rd != '0)) arch_rat[cmt_rd] <= cmt_prd;
      if (do_flush) begin
        // Restore from the retirement RAT including a commit retiring this same cycle.
        for (int i = 0; i < ARCH; i++) begin
          spec_rat[i] <= (cmt_we && (cmt_rd == AW'(i)) && (i != 0)) ? cmt_prd : arch_rat[i];
        end
      end else if (fl_alloc) begin
        spec_rat[ren_rd] <= fl_prd;
      end
    end
  end

  // Stage p1: registered renamed uop, held until the consumer accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      uop_p1 <= '0;
    end else begin
      if (do_flush)       vld_p1 <= 1'b0;
      else if (fire)      vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
      if (fire) uop_p1 <= uop_p0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_prs1    = uop_p1.prs1;
  assign out_prs2    = uop_p1.prs2;
  assign out_prd     = uop_p1.prd;
  assign out_old_prd = uop_p1.old_prd;
  assign out_rd_we   = uop_p1.rd_we;

  a_no_cmt_in_reclaim: assert property (
    @(posedge clk) disable iff (!rst_n) (state == RECLAIM) |-> !cmt_valid
  );

endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: vector table for single-uop renames plus hand-written
// stall, commit and flush/reclaim sequences.
module tb_rename_map;
  import rename_map_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ren_valid, ren_ready;
  logic [AW-1:0] ren_rs1, ren_rs2, ren_rd;
  logic          ren_rd_we;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic          out_rd_we;
  logic          fl_alloc, fl_alloc_ok;
  logic [PW-1:0] fl_prd;
  logic          fl_free_en;
  logic [PW-1:0] fl_prd_free;
  logic          cmt_valid, cmt_rd_we;
  logic [AW-1:0] cmt_rd;
  logic [PW-1:0] cmt_prd, cmt_old_prd;
  logic          flush, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rename_map dut (
    .clk(clk), .rst_n(rst_n),
    .ren_valid(ren_valid), .ren_ready(ren_ready),
    .ren_rs1(ren_rs1), .ren_rs2(ren_rs2), .ren_rd(ren_rd), .ren_rd_we(ren_rd_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rd_we(out_rd_we),
    .fl_alloc(fl_alloc), .fl_alloc_ok(fl_alloc_ok), .fl_prd(fl_prd),
    .fl_free_en(fl_free_en), .fl_prd_free(fl_prd_free),
    .cmt_valid(cmt_valid), .cmt_rd_we(cmt_rd_we), .cmt_rd(cmt_rd),
    .cmt_prd(cmt_prd), .cmt_old_prd(cmt_old_prd),
    .flush(flush), .busy(busy)
  );

  typedef struct {
    logic [AW-1:0] rs1, rs2, rd;
    logic          we, ok;
    logic [PW-1:0] fl;
    logic          ready, alloc;
    logic [PW-1:0] prs1, prs2, prd, old;
    logic          rdwe;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic we, input logic [PW-1:0] fl);
    ren_valid = v; ren_rs1 = rs1; ren_rs2 = rs2; ren_rd = rd; ren_rd_we = we; fl_prd = fl;
  endtask

  task automatic commit(input logic v, input logic [AW-1:0] rd, input logic [PW-1:0] prd,
                        input logic [PW-1:0] old);
    cmt_valid = v; cmt_rd_we = v; cmt_rd = rd; cmt_prd = prd; cmt_old_prd = old;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_uop(input string tag, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                         input logic [PW-1:0] pd, input logic [PW-1:0] op, input logic we);
    chk({tag, ".prs1"},    32'(out_prs1),    32'(p1));
    chk({tag, ".prs2"},    32'(out_prs2),    32'(p2));
    chk({tag, ".prd"},     32'(out_prd),     32'(pd));
    chk({tag, ".old_prd"}, 32'(out_old_prd), 32'(op));
    chk({tag, ".rd_we"},   32'(out_rd_we),   32'(we));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{rs1:1, rs2:2, rd:3, we:1, ok:1, fl:32, ready:1, alloc:1, prs1:1,  prs2:2,  prd:32, old:3,  rdwe:1};
    tbl[1] = '{rs1:3, rs2:0, rd:3, we:1, ok:1, fl:33, ready:1, alloc:1, prs1:32, prs2:0,  prd:33, old:32, rdwe:1};
    tbl[2] = '{rs1:3, rs2:3, rd:0, we:1, ok:0, fl:34, ready:1, alloc:0, prs1:33, prs2:33, prd:0,  old:0,  rdwe:0};
    tbl[3] = '{rs1:5, rs2:6, rd:7, we:0, ok:1, fl:34, ready:1, alloc:0, prs1:5,  prs2:6,  prd:0,  old:7,  rdwe:0};
    tbl[4] = '{rs1:3, rs2:1, rd:8, we:1, ok:0, fl:34, ready:0, alloc:0, prs1:0,  prs2:0,  prd:0,  old:0,  rdwe:0};
    tbl[5] = '{rs1:8, rs2:3, rd:8, we:1, ok:1, fl:34, ready:1, alloc:1, prs1:8,  prs2:33, prd:34, old:8,  rdwe:1};

    drive(0, 0, 0, 0, 0, 0);
    commit(0, 0, 0, 0);
    out_ready = 1; fl_alloc_ok = 1; flush = 0;
    do_reset();

    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.ren_ready", 32'(ren_ready), 32'd1);
    chk("rst.fl_alloc",  32'(fl_alloc),  32'd0);
    chk("rst.fl_free",   32'(fl_free_en), 32'd0);
    chk("rst.out_prd",   32'(out_prd),   32'd0);

    for (int i = 0; i < 6; i++) begin
      drive(1, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].fl);
      fl_alloc_ok = tbl[i].ok;
      #1;
      chk($sformatf("v%0d.ren_ready", i), 32'(ren_ready), 32'(tbl[i].ready));
      chk($sformatf("v%0d.fl_alloc", i),  32'(fl_alloc),  32'(tbl[i].alloc));
      tick();
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ready));
      if (tbl[i].ready)
        chk_uop($sformatf("v%0d", i), tbl[i].prs1, tbl[i].prs2, tbl[i].prd, tbl[i].old, tbl[i].rdwe);
    end
    fl_alloc_ok = 1;

    // Backpressure: uop A lands in the output register, then stalls B for 3 cycles.
    drive(1, 8, 9, 9, 1, 35);
    tick();
    chk_uop("stA", 34, 9, 35, 9, 1);
    out_ready = 0;
    drive(1, 9, 0, 10, 1, 36);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall.ren_ready", 32'(ren_ready), 32'd0);
      chk("stall.fl_alloc",  32'(fl_alloc),  32'd0);
      tick();
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk("stall.out_prd",   32'(out_prd),   32'd35);
      chk("stall.out_prs1",  32'(out_prs1),  32'd34);
    end
    out_ready = 1;
    #1;
    chk("unstall.ren_ready", 32'(ren_ready), 32'd1);
    chk("unstall.fl_alloc",  32'(fl_alloc),  32'd1);
    tick();
    chk_uop("stB", 35, 0, 36, 10, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Commit alongside a fire, then flush and reclaim the squashed registers.
    do_reset();
    drive(1, 1, 2, 3, 1, 32);
    tick();
    drive(1, 3, 0, 4, 1, 33);
    commit(1, 3, 32, 3);
    #1;
    chk("cmt.fl_free_en",  32'(fl_free_en),  32'd1);
    chk("cmt.fl_prd_free", 32'(fl_prd_free), 32'd3);
    chk("cmt.fl_alloc",    32'(fl_alloc),    32'd1);
    tick();
    commit(0, 0, 0, 0);
    chk_uop("cmtB", 32, 0, 33, 4, 1);
    drive(1, 0, 0, 5, 1, 34);
    tick();
    drive(1, 0, 0, 6, 1, 35);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    flush = 1;
    #1;
    chk("fl.ren_ready",  32'(ren_ready),  32'd0);
    chk("fl.fl_free_en", 32'(fl_free_en), 32'd0);
    tick();
    flush = 0;
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rcl.busy",        32'(busy),        32'd1);
      chk("rcl.ren_ready",   32'(ren_ready),   32'd0);
      chk("rcl.fl_free_en",  32'(fl_free_en),  32'd1);
      chk("rcl.fl_prd_free", 32'(fl_prd_free), 32'(33 + k));
      tick();
    end
    chk("rcl.last_busy", 32'(busy),       32'd1);
    chk("rcl.last_free", 32'(fl_free_en), 32'd0);
    tick();
    chk("rcl.done_busy",  32'(busy),      32'd0);
    chk("rcl.done_ready", 32'(ren_ready), 32'd1);

    // Spec RAT now mirrors arch RAT: x3->32, x4 and x5 back to identity.
    drive(1, 3, 4, 5, 1, 36);
    tick();
    chk_uop("post", 32, 4, 36, 5, 1);

    // Flush with a same-cycle commit of the only in-flight register: nothing to reclaim.
    drive(0, 0, 0, 0, 0, 0);
    flush = 1;
    commit(1, 5, 36, 5);
    #1;
    chk("flc.fl_free_en",  32'(fl_free_en),  32'd1);
    chk("flc.fl_prd_free", 32'(fl_prd_free), 32'd5);
    tick();
    flush = 0;
    commit(0, 0, 0, 0);
    chk("flc.busy",       32'(busy),       32'd1);
    chk("flc.fl_free_en", 32'(fl_free_en), 32'd0);
    tick();
    chk("flc.idle_busy",  32'(busy),       32'd0);
    drive(1, 5, 6, 0, 0, 0);
    tick();
    chk_uop("flc.post", 36, 6, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
